// File: rtl/ooo_pkg.sv
// Shared out-of-order core sizing: physical/architectural register counts and tag type.
package ooo_pkg;
    localparam int TAG_W    = 5;
    localparam int NUM_PHYS = 1 << TAG_W;
    localparam int NUM_ARCH = 16;
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    typedef logic [TAG_W-1:0] tag_t;
endpackage

// File: rtl/phys_free_list_if.sv
// Rename/commit side bundle of the physical register free list.
interface phys_free_list_if #(
    parameter int TAG_W = ooo_pkg::TAG_W,
    parameter int CNT_W = ooo_pkg::CNT_W
);
    logic             alloc_ack;
    logic             alloc_valid;
    logic [TAG_W-1:0] alloc_tag;
    logic             release_valid;
    logic [TAG_W-1:0] release_tag;
    logic [CNT_W-1:0] free_count;
    logic             err;

    modport master (
        output alloc_ack, release_valid, release_tag,
        input  alloc_valid, alloc_tag, free_count, err
    );

    modport slave (
        input  alloc_ack, release_valid, release_tag,
        output alloc_valid, alloc_tag, free_count, err
    );
endinterface

// File: rtl/phys_free_list_ring_ptr.sv
// Circular-buffer pointer: index wraps DEPTH-1 -> 0 and toggles a wrap bit.
module ring_ptr #(
    parameter int   DEPTH    = 16,
    parameter int   IDX_W    = $clog2(DEPTH),
    parameter logic RST_WRAP = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             wrap
);
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        idx_d  = idx_q;
        wrap_d = wrap_q;
        if (en) begin
            if (idx_q == IDX_W'(DEPTH - 1)) begin
                idx_d  = '0;
                wrap_d = ~wrap_q;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            wrap_q <= RST_WRAP;
        end else begin
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign idx  = idx_q;
    assign wrap = wrap_q;
endmodule

// File: rtl/phys_free_list.sv
// Physical register free list: show-ahead FIFO of free tags plus a free bitmap
// that screens out double frees. Comes out of reset holding every non-architectural tag.
module phys_free_list #(
    parameter int TAG_W    = ooo_pkg::TAG_W,
    parameter int NUM_PHYS = ooo_pkg::NUM_PHYS,
    parameter int NUM_ARCH = ooo_pkg::NUM_ARCH
) (
    input  logic             clk,
    input  logic             reset,
    phys_free_list_if.slave  fl
);
    localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int IDX_W    = $clog2(FL_DEPTH);
    localparam int CNT_W    = $clog2(FL_DEPTH + 1);
    localparam logic [NUM_PHYS-1:0] BMAP_RST = {NUM_PHYS{1'b1}} << NUM_ARCH;

    import ooo_pkg::*;

    logic [TAG_W-1:0]    entry_q [FL_DEPTH];
    logic [TAG_W-1:0]    entry_d [FL_DEPTH];
    logic [NUM_PHYS-1:0] bitmap_q, bitmap_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;

    logic [IDX_W-1:0]    head_idx, tail_idx;
    logic                head_wrap, tail_wrap;
    logic                full, alloc_valid;
    logic [TAG_W-1:0]    alloc_tag;
    logic                pop, push, ack_err, dbl_free, overflow;

    ring_ptr #(.DEPTH(FL_DEPTH), .IDX_W(IDX_W), .RST_WRAP(1'b0)) u_head (
        .clk(clk), .reset(reset), .en(pop), .idx(head_idx), .wrap(head_wrap)
    );

    ring_ptr #(.DEPTH(FL_DEPTH), .IDX_W(IDX_W), .RST_WRAP(1'b1)) u_tail (
        .clk(clk), .reset(reset), .en(push), .idx(tail_idx), .wrap(tail_wrap)
    );

    assign full        = (head_idx == tail_idx) && (head_wrap != tail_wrap);
    assign alloc_valid = (count_q != '0);
    assign alloc_tag   = entry_q[head_idx];

    // A release never bypasses to alloc_tag; a pop in the same cycle frees a slot when full.
    assign pop      = fl.alloc_ack && alloc_valid;
    assign ack_err  = fl.alloc_ack && !alloc_valid;
    assign dbl_free = fl.release_valid && bitmap_q[fl.release_tag];
    assign overflow = fl.release_valid && !dbl_free && full && !pop;
    assign push     = fl.release_valid && !dbl_free && !overflow;

    always_comb begin
        entry_d  = entry_q;
        bitmap_d = bitmap_q;
        count_d  = count_q;
        err_d    = err_q | ack_err | dbl_free | overflow;
        if (pop) begin
            bitmap_d[alloc_tag] = 1'b0;
        end
        if (push) begin
            entry_d[tail_idx]         = fl.release_tag;
            bitmap_d[fl.release_tag] = 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry_q[i] <= TAG_W'(NUM_ARCH + i);
            end
            bitmap_q <= BMAP_RST;
            count_q  <= CNT_W'(FL_DEPTH);
            err_q    <= 1'b0;
        end else begin
            entry_q  <= entry_d;
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign fl.alloc_valid = alloc_valid;
    assign fl.alloc_tag   = alloc_tag;
    assign fl.free_count  = count_q;
    assign fl.err         = err_q;
endmodule
